// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared ALU constants and the multiplier control-state encoding.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int MUL_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/adder_32b.sv
`default_nettype none
// ============================================================================
// adder_32b : 32-bit combinational adder with carry-out and signed overflow.
// Revision: 1.0
// ============================================================================
module adder_32b (
  input  logic [31:0] i0,
  input  logic [31:0] i1,
  input  logic        cin,
  output logic        cout,
  output logic [31:0] sum,
  output logic        ovflw
);

  assign {cout, sum} = {1'b0, i0} + {1'b0, i1} + {32'b0, cin};
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign ovflw = (i0[31] == i1[31]) && (sum[31] != i0[31]);

endmodule
`default_nettype wire

// File: rtl/seq_multiplier_32b.sv
`default_nettype none
// ============================================================================
// seq_multiplier_32b : unsigned 32x32->64 shift-and-add multiplier, one
// multiplier bit per clock, start/busy/done handshake.
// Revision: 1.0
// ============================================================================
module seq_multiplier_32b
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_e       state_q, state_d;
  logic [31:0]      mcand_q, mcand_d;
  logic [63:0]      acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [31:0] add_i1;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        unused_ovflw;

  // A zero addend leaves the upper half unchanged with cout=0.
  assign add_i1 = acc_q[0] ? mcand_q : 32'd0;

  adder_32b u_adder (
    .i0    (acc_q[63:32]),
    .i1    (add_i1),
    .cin   (1'b0),
    .cout  (add_cout),
    .sum   (add_sum),
    .ovflw (unused_ovflw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          mcand_d = multiplicand;
          acc_d   = {32'd0, multiplier};
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // 65-bit logical right shift of {cout, sum, acc[31:0]}.
        acc_d = {add_cout, add_sum, acc_q[31:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier_32b.sv
`default_nettype none
// ============================================================================
// tb_seq_multiplier_32b : self-checking bench for seq_multiplier_32b.
// Revision: 1.0
// ============================================================================
module tb_seq_multiplier_32b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  seq_multiplier_32b dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one multiply and waits (bounded) for done; returns edges from
  // the accept edge to done, the number of busy samples, and the product.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic [63:0] p);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    tick();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    multiplicand = 32'd3;
    multiplier = 32'd5;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [63:0] p;
    do_mul(32'd10, 32'd15, lat, bc, p);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL basic_latency got %0d required 32", lat);
    end
    checks++;
    if (bc !== 32) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d required 32", bc);
    end
    checks++;
    if (p !== 64'd150) begin
      errors++;
      $display("FAIL basic_product got %h required %h", p, 64'd150);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_in_done got %b required 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || product !== 64'd150) begin
      errors++;
      $display("FAIL basic_done_pulse_hold done=%b product=%h required 0 %h", done, product, 64'd150);
    end
  endtask

  task automatic test_max();
    int lat, bc;
    logic [63:0] p;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, p);
    checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001 || lat !== 32) begin
      errors++;
      $display("FAIL max_operands product=%h lat=%0d required %h 32", p, lat, 64'hFFFF_FFFE_0000_0001);
    end
    tick();
  endtask

  task automatic test_zero_carry();
    int lat, bc;
    logic [63:0] p;
    do_mul(32'd0, 32'h1234_5678, lat, bc, p);
    checks++;
    if (p !== 64'd0 || lat !== 32) begin
      errors++;
      $display("FAIL zero_operand product=%h lat=%0d required 0 32", p, lat);
    end
    tick();
    do_mul(32'h7FFF_FFFF, 32'd2, lat, bc, p);
    checks++;
    if (p !== 64'h0000_0000_FFFF_FFFE || lat !== 32) begin
      errors++;
      $display("FAIL carry_edge product=%h lat=%0d required %h 32", p, lat, 64'h0000_0000_FFFF_FFFE);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [63:0] p;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a[31] = 1'b1;
      if (i == 1) b[31:28] = 4'hF;
      do_mul(a, b, lat, bc, p);
      checks++;
      if (p !== ref_mul(a, b) || lat !== 32) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h product=%h lat=%0d required %h 32", i, a, b, p, lat, ref_mul(a, b));
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    start = 1'b1;
    multiplicand = 32'd114;
    multiplier = 32'd229;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 10) begin
      tick();
      n++;
    end
    start = 1'b1;
    multiplicand = 32'd7;
    multiplier = 32'd9;
    tick();
    n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32 || product !== ref_mul(32'd114, 32'd229)) begin
      errors++;
      $display("FAIL start_while_busy lat=%0d product=%h required 32 %h", n, product, ref_mul(32'd114, 32'd229));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    tick();
    multiplicand = 32'h0001_0000;
    multiplier = 32'h0001_0000;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32 || product !== ref_mul(a, b)) begin
      errors++;
      $display("FAIL b2b_first lat=%0d product=%h required 32 %h", n, product, ref_mul(a, b));
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept busy=%b done=%b required 1 0", busy, done);
    end
    n = 1;
    while (done !== 1'b1 && n < 45) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 33 || product !== 64'h0000_0001_0000_0000) begin
      errors++;
      $display("FAIL b2b_second gap=%0d product=%h required 33 %h", n, product, 64'h0000_0001_0000_0000);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen, lat, bc;
    logic [63:0] p;
    start = 1'b1;
    multiplicand = 32'hDEAD_BEEF;
    multiplier = 32'h1234_5678;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done active_cycles=%0d required 0", seen);
    end
    do_mul(32'd1234, 32'd5678, lat, bc, p);
    checks++;
    if (p !== ref_mul(32'd1234, 32'd5678) || lat !== 32) begin
      errors++;
      $display("FAIL reset_mid_recover product=%h lat=%0d required %h 32", p, lat, ref_mul(32'd1234, 32'd5678));
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = 32'd0;
    multiplier = 32'd0;
    test_reset();
    test_basic();
    test_max();
    test_zero_carry();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
